// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL bring-up and supervision sequencer.
//   Pulses the PLL reset, waits for a synchronized lock, requires the lock to
//   hold for LOCK_STABLE cycles, then releases the downstream reset. While
//   running, it accepts dynamic phase/duty updates and holds pll_ok low while
//   the PLL settles. A lock loss restarts the sequence. Too many failed lock
//   attempts park the block in FAIL until reset.
// Ports:
//   clkin        single clock (PLL reference domain)
//   reset        synchronous, active-high
//   pll_lock     PLL LOCK, asynchronous; double-flop synchronized to lock_s
//   pll_reset    PLL RESET, active-high
//   psda, dutyda dynamic phase / duty codes driven to the PLL
//   cfg_valid, cfg_psda, cfg_dutyda, cfg_ready   update request handshake
//   sys_reset    downstream reset, active-high
//   pll_ok       locked, stable and not settling
//   err_timeout  sticky: MAX_RETRY lock attempts failed
//   retry_cnt    failed lock attempts since the last RUN entry
module pll_lock_seq #(
  parameter int         RST_CYCLES    = 16,
  parameter int         LOCK_TIMEOUT  = 4096,
  parameter int         LOCK_STABLE   = 256,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         MAX_RETRY     = 3,
  parameter logic [3:0] PSDA_INIT     = 4'b0000,
  parameter logic [3:0] DUTYDA_INIT   = 4'b1000
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [3:0] psda,
  output logic [3:0] dutyda,
  input  logic       cfg_valid,
  input  logic [3:0] cfg_psda,
  input  logic [3:0] cfg_dutyda,
  output logic       cfg_ready,
  output logic       sys_reset,
  output logic       pll_ok,
  output logic       err_timeout,
  output logic [2:0] retry_cnt
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX_B = (LOCK_STABLE > SETTLE_CYCLES) ? LOCK_STABLE : SETTLE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    RST_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    UPDATE,
    FAIL
  } state_t;

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [2:0]       retry_inc;

  // Both counters saturate instead of wrapping.
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign retry_inc = (retry_cnt == 3'd7) ? retry_cnt : retry_cnt + 3'd1;

  // A lock loss in RUN masks the handshake in the same cycle.
  assign cfg_ready = (state == RUN) && lock_s;

  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_meta   <= 1'b0;
      lock_s      <= 1'b0;
      state       <= RST_PLL;
      cnt         <= '0;
      pll_reset   <= 1'b1;
      sys_reset   <= 1'b1;
      pll_ok      <= 1'b0;
      err_timeout <= 1'b0;
      retry_cnt   <= '0;
      psda        <= PSDA_INIT;
      dutyda      <= DUTYDA_INIT;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      unique case (state)
        RST_PLL: begin
          if (cnt == RST_LAST) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            // The cycle that first sees lock counts as stable cycle 1.
            state <= STABLE;
            cnt   <= CNT_W'(1);
          end else if (cnt == TIMEOUT_LAST) begin
            retry_cnt <= retry_inc;
            cnt       <= '0;
            if (retry_inc == RETRY_LIMIT) begin
              state       <= FAIL;
              err_timeout <= 1'b1;
            end else begin
              state     <= RST_PLL;
              pll_reset <= 1'b1;
            end
          end else begin
            cnt <= cnt_inc;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_reset <= 1'b0;
            pll_ok    <= 1'b1;
            retry_cnt <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state     <= RST_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            pll_ok    <= 1'b0;
          end else if (cfg_valid) begin
            psda   <= cfg_psda;
            dutyda <= cfg_dutyda;
            state  <= UPDATE;
            cnt    <= '0;
            pll_ok <= 1'b0;
          end
        end
        UPDATE: begin
          if (!lock_s) begin
            state     <= RST_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            pll_ok    <= 1'b0;
          end else if (cnt == SETTLE_LAST) begin
            state  <= RUN;
            cnt    <= '0;
            pll_ok <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        FAIL: begin
          pll_reset   <= 1'b0;
          sys_reset   <= 1'b1;
          pll_ok      <= 1'b0;
          err_timeout <= 1'b1;
        end
        default: begin
          state     <= RST_PLL;
          cnt       <= '0;
          pll_reset <= 1'b1;
          sys_reset <= 1'b1;
          pll_ok    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: directed and randomized checks of pll_lock_seq against a
// timestamp-based reference model of the sequencing rules.
module tb_pll_lock_seq;

  localparam int         RST_CYCLES    = 16;
  localparam int         LOCK_TIMEOUT  = 4096;
  localparam int         LOCK_STABLE   = 256;
  localparam int         SETTLE_CYCLES = 16;
  localparam int         MAX_RETRY     = 3;
  localparam logic [3:0] PSDA_INIT     = 4'h0;
  localparam logic [3:0] DUTYDA_INIT   = 4'h8;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       pll_lock   = 1'b0;
  logic       cfg_valid  = 1'b0;
  logic [3:0] cfg_psda   = 4'h0;
  logic [3:0] cfg_dutyda = 4'h0;
  logic       pll_reset;
  logic [3:0] psda;
  logic [3:0] dutyda;
  logic       cfg_ready;
  logic       sys_reset;
  logic       pll_ok;
  logic       err_timeout;
  logic [2:0] retry_cnt;

  pll_lock_seq #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_STABLE  (LOCK_STABLE),
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY),
    .PSDA_INIT    (PSDA_INIT),
    .DUTYDA_INIT  (DUTYDA_INIT)
  ) dut (
    .clkin      (clk),
    .reset      (reset),
    .pll_lock   (pll_lock),
    .pll_reset  (pll_reset),
    .psda       (psda),
    .dutyda     (dutyda),
    .cfg_valid  (cfg_valid),
    .cfg_psda   (cfg_psda),
    .cfg_dutyda (cfg_dutyda),
    .cfg_ready  (cfg_ready),
    .sys_reset  (sys_reset),
    .pll_ok     (pll_ok),
    .err_timeout(err_timeout),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Reference model: a mode plus the cycle index at which it was entered.
  typedef enum {M_PRST, M_WAIT, M_STAB, M_RUN, M_UPD, M_FAIL} mmode_t;
  mmode_t     m_mode  = M_PRST;
  int         m_enter = 0;
  bit         m_meta  = 1'b0;
  bit         m_ls    = 1'b0;
  int         m_retry = 0;
  bit         m_err   = 1'b0;
  logic [3:0] m_psda  = PSDA_INIT;
  logic [3:0] m_duty  = DUTYDA_INIT;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int     dw;
    mmode_t nxt;
    dw  = cyc - m_enter + 1;   // cycles spent in the current mode, this one included
    nxt = m_mode;
    if (reset) begin
      nxt     = M_PRST;
      m_retry = 0;
      m_err   = 1'b0;
      m_psda  = PSDA_INIT;
      m_duty  = DUTYDA_INIT;
      m_meta  = 1'b0;
      m_ls    = 1'b0;
      m_enter = cyc + 1;
    end else begin
      case (m_mode)
        M_PRST: if (dw >= RST_CYCLES) nxt = M_WAIT;
        M_WAIT: begin
          if (m_ls) nxt = M_STAB;
          else if (dw >= LOCK_TIMEOUT) begin
            m_retry = (m_retry < 7) ? m_retry + 1 : 7;
            if (m_retry == MAX_RETRY) begin
              nxt   = M_FAIL;
              m_err = 1'b1;
            end else begin
              nxt = M_PRST;
            end
          end
        end
        M_STAB: begin
          // lock-high streak = the detecting WAIT cycle + cycles in STAB
          if (!m_ls) nxt = M_WAIT;
          else if (dw + 1 >= LOCK_STABLE) begin
            nxt     = M_RUN;
            m_retry = 0;
          end
        end
        M_RUN: begin
          if (!m_ls) nxt = M_PRST;
          else if (cfg_valid) begin
            m_psda = cfg_psda;
            m_duty = cfg_dutyda;
            nxt    = M_UPD;
          end
        end
        M_UPD: begin
          if (!m_ls) nxt = M_PRST;
          else if (dw >= SETTLE_CYCLES) nxt = M_RUN;
        end
        default: m_err = 1'b1;
      endcase
      m_ls   = m_meta;
      m_meta = pll_lock;
      if (nxt != m_mode) m_enter = cyc + 1;
    end
    m_mode = nxt;
    cyc++;
  endtask

  task automatic tick();
    #1;
    if (cyc > 0) chk("cfg_ready", cfg_ready, (m_mode == M_RUN) && m_ls);
    @(posedge clk);
    model_edge();
    #1;
    chk("pll_reset",   pll_reset,   m_mode == M_PRST);
    chk("sys_reset",   sys_reset,   !(m_mode == M_RUN || m_mode == M_UPD));
    chk("pll_ok",      pll_ok,      m_mode == M_RUN);
    chk("err_timeout", err_timeout, m_err);
    chk("retry_cnt",   retry_cnt,   m_retry);
    chk("psda",        psda,        m_psda);
    chk("dutyda",      dutyda,      m_duty);
  endtask

  initial begin
    int         n;
    int         drop_left;
    int         pulses;
    logic       prev_rst;
    logic [3:0] keep_psda;
    logic [3:0] keep_duty;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_psda",   psda,   4'h0);
    chk("rst_dutyda", dutyda, 4'h8);

    // Normal bring-up: PLL reset pulse, lock from cycle 30
    reset = 1'b0;
    n = 0;
    while (pll_reset === 1'b1 && n < 100) begin tick(); n++; end
    chk("pll_reset_len", n, 16);
    repeat (13) tick();
    pll_lock = 1'b1;
    n = 0;
    while (pll_ok !== 1'b1 && n < 1000) begin tick(); n++; end
    chk("lock_to_ok", n, 2 + 256);
    chk("run_sys_reset", sys_reset, 1'b0);

    // Dynamic update
    cfg_valid = 1'b1; cfg_psda = 4'h5; cfg_dutyda = 4'h6;
    tick();
    cfg_valid = 1'b0;
    chk("upd_psda",   psda,   4'h5);
    chk("upd_dutyda", dutyda, 4'h6);
    n = 0;
    while (pll_ok !== 1'b1 && n < 100) begin
      tick(); n++;
      chk("upd_sys_reset", sys_reset, 1'b0);
    end
    chk("settle_len", n, 16);

    // Randomized traffic with occasional lock drops and resets
    drop_left = 0;
    for (int i = 0; i < 3000; i++) begin
      cfg_valid  = ($urandom_range(0, 3) == 0);
      cfg_psda   = 4'($urandom);
      cfg_dutyda = 4'($urandom);
      reset      = ($urandom_range(0, 1499) == 0);
      if (drop_left > 0) begin
        pll_lock = 1'b0;
        drop_left--;
      end else begin
        pll_lock = 1'b1;
        if ($urandom_range(0, 399) == 0) drop_left = $urandom_range(1, 4);
      end
      tick();
    end
    cfg_valid = 1'b0;
    reset     = 1'b0;

    // Glitch during STABLE
    reset = 1'b1; pll_lock = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    n = 0;
    while (pll_reset === 1'b1 && n < 100) begin tick(); n++; end
    repeat (100) tick();
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    n = 0;
    while (pll_ok !== 1'b1 && n < 1000) begin tick(); n++; end
    chk("glitch_to_ok", n, 2 + 256);
    chk("glitch_retry", retry_cnt, 3'd0);

    // Lock loss colliding with a request
    keep_psda = psda;
    keep_duty = dutyda;
    pll_lock = 1'b0;
    repeat (2) tick();
    cfg_valid = 1'b1; cfg_psda = 4'hA; cfg_dutyda = 4'hB;
    #1;
    chk("collide_ready", cfg_ready, 1'b0);
    tick();
    cfg_valid = 1'b0;
    chk("collide_psda",   psda,      keep_psda);
    chk("collide_dutyda", dutyda,    keep_duty);
    chk("collide_prst",   pll_reset, 1'b1);

    // Reset in the middle of an update
    pll_lock = 1'b1;
    n = 0;
    while (pll_ok !== 1'b1 && n < 2000) begin tick(); n++; end
    chk("relock_ok", pll_ok, 1'b1);
    cfg_valid = 1'b1; cfg_psda = 4'h3; cfg_dutyda = 4'hC;
    tick();
    cfg_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("midupd_psda",   psda,      4'h0);
    chk("midupd_dutyda", dutyda,    4'h8);
    chk("midupd_prst",   pll_reset, 1'b1);
    chk("midupd_sysrst", sys_reset, 1'b1);

    // Lock never arrives: retries then FAIL
    pll_lock = 1'b0;
    tick();
    reset = 1'b0;
    pulses   = 1;
    prev_rst = pll_reset;
    n = 0;
    while (err_timeout !== 1'b1 && n < 20000) begin
      tick(); n++;
      if (pll_reset === 1'b1 && prev_rst === 1'b0) begin
        pulses++;
        chk("retry_at_pulse", retry_cnt, pulses - 1);
      end
      prev_rst = pll_reset;
    end
    chk("fail_pulses", pulses,      3);
    chk("fail_retry",  retry_cnt,   3'd3);
    chk("fail_err",    err_timeout, 1'b1);
    pll_lock = 1'b1;
    repeat (300) tick();
    chk("fail_sticky_sysrst", sys_reset, 1'b1);
    chk("fail_sticky_err",    err_timeout, 1'b1);

    // Reset out of FAIL restarts the sequence
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("fail_exit_err", err_timeout, 1'b0);
    chk("fail_exit_prst", pll_reset, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
